datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Issues a stored program of 16-bit datapath control words to the Datapath block, one per clock.
//  Holds the program in an internal word array loaded over a simple write port while idle.
//  Presents the fields DA/AA/BA/MB/FS/MD/RW on start, and captures the status flags for each step.
//  Sits between the board-level top and Datapath; replaces the manual load of one OPcode per button press.
// PARAMETERS
//  DEPTH   16  number of program words
//  AW      4   program address width, clog2(DEPTH)
// PORTS
//  clk        in   1    system clock; all state updates on posedge
//  reset_b    in   1    asynchronous reset, active-low
//  start      in   1    one-cycle pulse (already debounced): run program from word 0
//  abort      in   1    stop a running program at the next edge
//  prog_we    in   1    write prog_data into word prog_addr (accepted in IDLE only)
//  prog_addr  in   AW   program write address
//  prog_data  in   16   control word {DA[2:0],AA[2:0],BA[2:0],MB,FS[3:0],MD,RW}
//  prog_len   in   AW+1 number of words to run, sampled on start; values >DEPTH clamp to DEPTH
//  flags_in   in   4    {C,V,D,Z} from Datapath for the word currently issued
//  DA,AA,BA   out  3    destination / A / B register addresses
//  MB,MD      out  1    B-mux and D-mux selects
//  FS         out  4    function select
//  RW         out  1    register write enable; only 1 during an issue cycle
//  busy       out  1    1 while state is RUN
//  done       out  1    one-cycle pulse after the final word completes
//  pc_out     out  AW   index of the word currently issued
//  flags_q    out  4    flags captured from the most recent completed word
// BEHAVIOUR
//  Reset (async, reset_b=0): state=IDLE; pc=0; all control outputs=0 (RW=0); busy=0; done=0;
//   flags_q=0; latched length=0. The program array is not cleared and keeps its contents.
//  States: IDLE -> RUN -> DONE -> IDLE. Control outputs are registered. Outside RUN they are all 0.
//  IDLE: prog_we=1 writes the array at the edge. start=1 with prog_we=0 latches len=min(prog_len,DEPTH).
//   If len=0, go to DONE and issue no words. Otherwise go to RUN with pc=0 and outputs=word[0].
//   start and prog_we in the same cycle: the write is performed and start is ignored.
//  RUN: each edge latches flags_q<=flags_in for the issued word.
//   If pc==len-1, go to DONE and zero the outputs. Otherwise pc<=pc+1 and outputs<=word[pc+1].
//   The word at index k is issued during the (k+1)th cycle after start is sampled.
//   Running len words takes len cycles of busy. done is high in the following cycle.
//  abort in RUN: next edge goes to IDLE with outputs zeroed. flags_q is not updated, done stays 0,
//   pc returns to 0. abort has priority over the end-of-program transition. abort outside RUN is ignored.
//  start or prog_we during RUN/DONE: ignored, and the array is not modified.
//  DONE: done=1 for exactly one cycle, then IDLE. pc returns to 0.
//  No address wrap: pc never exceeds len-1 <= DEPTH-1.
//  Reset mid-RUN: immediate IDLE, RW drops to 0 asynchronously, so no further register writes occur.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: adds input port step (1 bit, debounced pulse).
//   In RUN the current word stays on the outputs, but RW is gated to 0 except in cycles with step=1.
//   pc advance, flags latch and the end-of-program check occur only on edges where step=1.
//   abort still acts on any edge.
//  Not defined: no step port; the sequencer advances every cycle as described above.
// TESTING
//  1. Load words 0..2 = 16'h2081,16'h4101,16'h6183. Pulse start with prog_len=3.
//     Expect busy for 3 cycles, pc_out=0,1,2, and RW=1,1,1. done pulses in cycle 4, then IDLE.
//  2. prog_len=0, then pulse start. Expect no RW, busy stays 0, done pulses the next cycle.
//  3. prog_len=20 with DEPTH=16. Expect exactly 16 issue cycles, pc_out stops at 15, done once.
//  4. Pulse abort while pc_out=1 of a 4-word program. Expect outputs=0 next cycle, done stays 0,
//     and flags_q holds the word-0 flags.
//  5. Drop reset_b mid-RUN. Expect RW=0 and busy=0 immediately. After release, start replays
//     the same program, proving the array was retained.
//  6. (SEQ_SINGLE_STEP_EN) 2-word program with step pulsed every 3rd cycle.
//     Expect each word held until its step, RW high only in step cycles, and done after the 2nd step.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Issues a stored program of 16-bit datapath control words, one per clock, and captures status flags.
// Optional build macro SEQ_SINGLE_STEP_EN adds a step input that gates issue and advance.
module datapath_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_b,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic          step,
`endif
    input  logic          start,
    input  logic          abort,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic [3:0]    flags_in,
    output logic [2:0]    DA,
    output logic [2:0]    AA,
    output logic [2:0]    BA,
    output logic          MB,
    output logic          MD,
    output logic [3:0]    FS,
    output logic          RW,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc_out,
    output logic [3:0]    flags_q,
    output logic [1:0]    state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [15:0]   ctrl_q, ctrl_d;
    logic [3:0]    flags_d, flags_r;
    logic          done_q, done_d;
    logic          mem_we;
    logic          advance;
    logic          last_word;
    logic [AW:0]   len_clamp;
    logic [AW-1:0] pc_inc;
    logic [15:0]   mem_q [DEPTH];

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_word = ({1'b0, pc_q} == (len_q - 1'b1));
    assign pc_inc    = pc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        ctrl_d  = ctrl_q;
        flags_d = flags_r;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ctrl_d = 16'h0000;
                pc_d   = '0;
                // A write wins over start in the same cycle.
                if (prog_we) begin
                    mem_we = 1'b1;
                end else if (start) begin
                    len_d = len_clamp;
                    if (len_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        ctrl_d  = mem_q[0];
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ctrl_d  = 16'h0000;
                    pc_d    = '0;
                end else if (advance) begin
                    flags_d = flags_in;
                    if (last_word) begin
                        state_d = S_DONE;
                        ctrl_d  = 16'h0000;
                    end else begin
                        pc_d   = pc_inc;
                        ctrl_d = mem_q[pc_inc];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ctrl_d  = 16'h0000;
                pc_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                ctrl_d  = 16'h0000;
                pc_d    = '0;
            end
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            ctrl_q  <= 16'h0000;
            flags_r <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            ctrl_q  <= ctrl_d;
            flags_r <= flags_d;
            done_q  <= done_d;
        end
    end

    // Program storage survives reset so a program can be replayed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign DA        = ctrl_q[15:13];
    assign AA        = ctrl_q[12:10];
    assign BA        = ctrl_q[9:7];
    assign MB        = ctrl_q[6];
    assign FS        = ctrl_q[5:2];
    assign MD        = ctrl_q[1];
`ifdef SEQ_SINGLE_STEP_EN
    assign RW        = ctrl_q[0] & step;
`else
    assign RW        = ctrl_q[0];
`endif
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign pc_out    = pc_q;
    assign flags_q   = flags_r;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: run, empty run, clamp, abort, reset retention, optional stepping.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [4:0]  prog_len = '0;
  logic [3:0]  flags_in = '0;
  logic [2:0]  da, aa, ba;
  logic        mb, md, rw;
  logic [3:0]  fs;
  logic        busy, done;
  logic [3:0]  pc_out;
  logic [3:0]  flags_q;
  logic [1:0]  state_dbg;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] prog [16];
  logic [15:0] ctrl_obs;

  assign ctrl_obs = {da, aa, ba, mb, fs, md, rw};

  datapath_sequencer dut (
    .clk(clk), .reset_b(reset_b),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .start(start), .abort(abort), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
    .flags_in(flags_in), .DA(da), .AA(aa), .BA(ba), .MB(mb), .MD(md), .FS(fs), .RW(rw),
    .busy(busy), .done(done), .pc_out(pc_out), .flags_q(flags_q), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] len);
    prog_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    prog[0] = 16'h2081;
    prog[1] = 16'h4101;
    prog[2] = 16'h6183;
    for (int i = 3; i < 16; i++) prog[i] = 16'(i * 16'h0111) | 16'h0001;

    // Reset state
    #12;
    chk("rst_ctrl", ctrl_obs, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pc", pc_out, 4'd0);
    chk("rst_flags", flags_q, 4'h0);
    chk("rst_state", state_dbg, 2'd0);
    @(negedge clk);
    reset_b = 1'b1;
    tick();

    // Test 1: three-word program
    for (int i = 0; i < 3; i++) write_word(4'(i), prog[i]);
    pulse_start(5'd3);
    flags_in = 4'hA;
    chk("t1_busy0", busy, 1'b1);
    chk("t1_pc0", pc_out, 4'd0);
    chk("t1_w0", ctrl_obs, 16'h2081);
    chk("t1_state_run", state_dbg, 2'd1);
    tick();
    flags_in = 4'h5;
    chk("t1_pc1", pc_out, 4'd1);
    chk("t1_w1", ctrl_obs, 16'h4101);
    chk("t1_fl0", flags_q, 4'hA);
    tick();
    flags_in = 4'h3;
    chk("t1_pc2", pc_out, 4'd2);
    chk("t1_w2", ctrl_obs, 16'h6183);
    chk("t1_rw2", rw, 1'b1);
    chk("t1_fl1", flags_q, 4'h5);
    tick();
    chk("t1_done", done, 1'b1);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_ctrl_off", ctrl_obs, 16'h0000);
    chk("t1_fl2", flags_q, 4'h3);
    chk("t1_state_done", state_dbg, 2'd2);
    tick();
    chk("t1_done_off", done, 1'b0);
    chk("t1_idle", state_dbg, 2'd0);
    chk("t1_pc_idle", pc_out, 4'd0);

    // Test 2: zero-length program
    pulse_start(5'd0);
    chk("t2_busy", busy, 1'b0);
    chk("t2_rw", rw, 1'b0);
    chk("t2_done", done, 1'b1);
    tick();
    chk("t2_done_off", done, 1'b0);

    // Test 3: length clamps to 16; start/write during RUN are ignored
    for (int i = 3; i < 16; i++) write_word(4'(i), prog[i]);
    pulse_start(5'd20);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t3_pc%0d", k), pc_out, 32'(k));
      chk($sformatf("t3_w%0d", k), ctrl_obs, prog[k]);
      chk($sformatf("t3_busy%0d", k), busy, 1'b1);
      if (k == 5) begin
        start = 1'b1;
        prog_we = 1'b1;
        prog_addr = 4'd7;
        prog_data = 16'hFFFF;
        prog_len = 5'd2;
      end else begin
        start = 1'b0;
        prog_we = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    prog_we = 1'b0;
    chk("t3_done", done, 1'b1);
    chk("t3_busy_off", busy, 1'b0);
    tick();
    chk("t3_done_off", done, 1'b0);

    // Test 4: abort at pc 1
    pulse_start(5'd4);
    flags_in = 4'h9;
    chk("t4_pc0", pc_out, 4'd0);
    tick();
    chk("t4_pc1", pc_out, 4'd1);
    abort = 1'b1;
    flags_in = 4'h6;
    tick();
    abort = 1'b0;
    chk("t4_ctrl", ctrl_obs, 16'h0000);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    chk("t4_flags", flags_q, 4'h9);
    chk("t4_pc", pc_out, 4'd0);
    tick();
    chk("t4_done_later", done, 1'b0);

    // Test 5: reset mid-run, then replay
    pulse_start(5'd3);
    tick();
    chk("t5_pc1", pc_out, 4'd1);
    #2 reset_b = 1'b0;
    #1;
    chk("t5_rw", rw, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_pc", pc_out, 4'd0);
    chk("t5_flags", flags_q, 4'h0);
    tick();
    reset_b = 1'b1;
    tick();
    pulse_start(5'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_w%0d", k), ctrl_obs, prog[k]);
      tick();
    end
    chk("t5_done", done, 1'b1);
    tick();

`ifdef SEQ_SINGLE_STEP_EN
    // Test 6: single step every third cycle
    pulse_start(5'd2);
    for (int c = 1; c <= 6; c++) begin
      step = (c % 3 == 0);
      #1;
      chk($sformatf("t6_rw%0d", c), rw, step);
      chk($sformatf("t6_pc%0d", c), pc_out, (c <= 3) ? 32'd0 : 32'd1);
      chk($sformatf("t6_w%0d", c), ctrl_obs[15:1], (c <= 3) ? prog[0][15:1] : prog[1][15:1]);
      tick();
    end
    step = 1'b0;
    chk("t6_done", done, 1'b1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
